// File: rtl/load_cell_a2d.sv
// load_cell_a2d
// SPI master that polls an ADC128S-style 8-channel A2D converter. Each
// accepted `nxt` request runs two SPI frames on the next channel of a fixed
// round-robin (ch0, ch4, ch5, ch6). Frame 1 sends the channel command.
// Frame 2 clocks back the 12-bit result, which is written into the holding
// register of that channel.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   nxt        in   one-clk conversion request, dropped while busy
//   lft_ld     out  latest channel-0 result (left load cell)
//   rght_ld    out  latest channel-4 result (right load cell)
//   steer_pot  out  latest channel-5 result
//   batt       out  latest channel-6 result
//   cnv_cmplt  out  one-clk pulse when a holding register updates
//   SS_n       out  A2D slave select, active low
//   SCLK       out  SPI clock, idles high
//   MOSI       out  command data to the A2D
//   MISO       in   result data from the A2D
`timescale 1ns/1ps

module load_cell_a2d #(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

    // The divider is preset one clk before SS_n falls. Counting starts on the
    // same edge that drops SS_n, so the first SCLK fall comes a quarter
    // period after SS_n falls.
    localparam logic [SCLK_DIV_W-1:0] DIV_PRESET = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE   = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL   = {SCLK_DIV_W{1'b1}};

    state_t                state_q;
    logic [SCLK_DIV_W-1:0] sclkDiv_q;
    logic [15:0]           shiftReg_q;
    logic [4:0]            bitCnt_q;
    logic                  misoSmp_q;
    logic                  ssN_q;
    logic                  cnvCmplt_q;
    logic [1:0]            rr_q;
    logic [11:0]           lftLd_q;
    logic [11:0]           rghtLd_q;
    logic [11:0]           steerPot_q;
    logic [11:0]           batt_q;

    logic risePt;
    logic fallPt;

    // Command word for the channel selected by the round-robin index.
    function automatic logic [15:0] cmdWord(input logic [1:0] idx);
        logic [2:0] ch;
        case (idx)
            2'd0:    ch = 3'd0;
            2'd1:    ch = 3'd4;
            2'd2:    ch = 3'd5;
            default: ch = 3'd6;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    // The divider value tells us which SCLK edge the next clk will produce.
    always_comb begin
        risePt = (sclkDiv_q == DIV_RISE);
        fallPt = (sclkDiv_q == DIV_FALL);
    end

    // Single sequential block: the conversion sequencer and the shared frame
    // engine. bitCnt_q counts fall points. The first fall point of a frame
    // only sets up the first bit. The 17th fall point shifts in the last
    // sample and ends the frame with SCLK frozen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sclkDiv_q  <= DIV_PRESET;
            shiftReg_q <= 16'h0000;
            bitCnt_q   <= 5'd0;
            misoSmp_q  <= 1'b0;
            ssN_q      <= 1'b1;
            cnvCmplt_q <= 1'b0;
            rr_q       <= 2'd0;
            lftLd_q    <= 12'h000;
            rghtLd_q   <= 12'h000;
            steerPot_q <= 12'h000;
            batt_q     <= 12'h000;
        end else begin
            cnvCmplt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (nxt) begin
                        shiftReg_q <= cmdWord(rr_q);
                        sclkDiv_q  <= DIV_PRESET;
                        bitCnt_q   <= 5'd0;
                        state_q    <= CMD;
                    end
                end
                CMD, READ: begin
                    if (risePt) begin
                        misoSmp_q <= MISO;
                    end
                    if (fallPt && (bitCnt_q == 5'd16)) begin
                        shiftReg_q <= {shiftReg_q[14:0], misoSmp_q};
                        ssN_q      <= 1'b1;
                        state_q    <= (state_q == CMD) ? GAP : DONE;
                    end else begin
                        ssN_q     <= 1'b0;
                        sclkDiv_q <= sclkDiv_q + SCLK_DIV_W'(1);
                        if (fallPt) begin
                            bitCnt_q <= bitCnt_q + 5'd1;
                            if (bitCnt_q != 5'd0) begin
                                shiftReg_q <= {shiftReg_q[14:0], misoSmp_q};
                            end
                        end
                    end
                end
                GAP: begin
                    // SS_n stays high this clk and the previous one. Loading
                    // here lets SS_n drop on the next edge.
                    shiftReg_q <= 16'h0000;
                    sclkDiv_q  <= DIV_PRESET;
                    bitCnt_q   <= 5'd0;
                    state_q    <= READ;
                end
                DONE: begin
                    case (rr_q)
                        2'd0:    lftLd_q    <= shiftReg_q[11:0];
                        2'd1:    rghtLd_q   <= shiftReg_q[11:0];
                        2'd2:    steerPot_q <= shiftReg_q[11:0];
                        default: batt_q     <= shiftReg_q[11:0];
                    endcase
                    cnvCmplt_q <= 1'b1;
                    rr_q       <= rr_q + 2'd1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lft_ld    = lftLd_q;
    assign rght_ld   = rghtLd_q;
    assign steer_pot = steerPot_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cnvCmplt_q;
    assign SS_n      = ssN_q;
    assign SCLK      = sclkDiv_q[SCLK_DIV_W-1];
    assign MOSI      = shiftReg_q[15];

endmodule

// File: tb/tb_load_cell_a2d.sv
// tb_load_cell_a2d
// Bench for load_cell_a2d. It contains an A2D slave model driven from the
// SPI pins, a frame-shape monitor, and a conversion-level model of the
// holding registers and cnv_cmplt timing. Directed sequences exercise reset,
// single and round-robin conversions, busy-time requests and reset mid-frame.
`timescale 1ns/1ps

module tb_load_cell_a2d;

    logic        clk;
    logic        rst;
    logic        nxt;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        cnv_cmplt;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int errCnt   = 0;
    int checkCnt = 0;

    // A2D contents, indexed by channel.
    logic [15:0] a2dData [8];
    int          chanMap [4] = '{0, 4, 5, 6};

    load_cell_a2d #(.SCLK_DIV_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCnt++;
        if (actual !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clk of stimulus. Inputs change 2ns after the rising edge.
    task automatic applyStimulus(input logic rstVal, input logic nxtVal);
        @(posedge clk);
        #2;
        rst = rstVal;
        nxt = nxtVal;
    endtask

    // Pulse nxt, then return at the negedge where cnv_cmplt is seen.
    // latency = edges from the edge that sampled nxt.
    task automatic runConversion(output int latency);
        logic found;
        found = 1'b0;
        latency = -1;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k < 1200 && !found; k++) begin
            @(negedge clk);
            if (cnv_cmplt) begin
                found   = 1'b1;
                latency = k;
            end
        end
        checkOutput("cnvTimeout", 64'(found), 64'(1));
    endtask

    // ------------------------------------------------------------------
    // A2D slave and frame-shape monitor, sampled on the falling clk edge.
    // Frame 1 of a conversion returns junk. Frame 2 returns the data of the
    // channel named in frame 1. MISO changes on SCLK falls.
    // ------------------------------------------------------------------
    int          monCyc      = 0;
    int          frameIdx    = 0;
    int          frameCount  = 0;
    int          lowCnt      = 0;
    int          highCnt     = 0;
    int          fallCnt     = 0;
    int          riseCnt     = 0;
    int          bitIdx      = 15;
    int          ssFallCyc   = 0;
    int          lastFallCyc = 0;
    logic [15:0] mosiWord    = 16'h0;
    logic [15:0] misoWord    = 16'h0;
    logic [15:0] lastCmdWord = 16'hFFFF;
    logic [2:0]  lastCh      = 3'd0;
    logic        prevSS      = 1'b1;
    logic        prevSclk    = 1'b1;
    logic        prevMosi    = 1'b0;

    // Conversion-level model state (written only by the compare process).
    logic [11:0] mRegs [4];
    int          mRr    = 0;
    logic        mBusy  = 1'b0;
    int          mEdge  = 0;
    int          mDue   = 0;
    logic        pNxt   = 1'b0;

    always @(negedge clk) begin
        monCyc++;
        if (rst) begin
            frameIdx = 0;
            MISO     = 1'b0;
            prevSS   = 1'b1;
            prevSclk = 1'b1;
        end else begin
            if (prevSS && !SS_n) begin
                if (frameIdx % 2 == 1) checkOutput("gapHigh", 64'(highCnt), 64'(2));
                lowCnt    = 1;
                fallCnt   = 0;
                riseCnt   = 0;
                mosiWord  = 16'h0;
                ssFallCyc = monCyc;
                misoWord  = (frameIdx % 2 == 1) ? a2dData[lastCh] : 16'hDEAD;
                bitIdx    = 15;
                MISO      = misoWord[15];
            end else if (!SS_n) begin
                lowCnt++;
                if (prevSclk && !SCLK) begin
                    fallCnt++;
                    if (fallCnt == 1) begin
                        checkOutput("firstFall", 64'(monCyc - ssFallCyc), 64'(8));
                    end else begin
                        checkOutput("sclkPeriod", 64'(monCyc - lastFallCyc), 64'(32));
                        bitIdx--;
                        if (bitIdx >= 0) MISO = misoWord[bitIdx];
                    end
                    lastFallCyc = monCyc;
                end else begin
                    checkOutput("mosiHold", 64'(MOSI), 64'(prevMosi));
                end
                if (!prevSclk && SCLK) begin
                    riseCnt++;
                    mosiWord = {mosiWord[14:0], MOSI};
                end
            end else if (!prevSS && SS_n) begin
                checkOutput("sclkFalls", 64'(fallCnt), 64'(16));
                checkOutput("sclkRises", 64'(riseCnt), 64'(16));
                checkOutput("ssLowLen", 64'(lowCnt), 64'(520));
                if (frameIdx % 2 == 0) begin
                    lastCmdWord = mosiWord;
                    lastCh      = mosiWord[13:11];
                    checkOutput("cmdWord", 64'(mosiWord), 64'(chanMap[mRr] << 11));
                end else begin
                    checkOutput("readWord", 64'(mosiWord), 64'(0));
                end
                frameIdx++;
                frameCount++;
                highCnt = 1;
            end else begin
                highCnt++;
            end
            prevSS   = SS_n;
            prevSclk = SCLK;
        end
        prevMosi = MOSI;
    end

    // ------------------------------------------------------------------
    // Compare process. A request seen while idle completes exactly 1044
    // edges later. The result is the A2D data of the round-robin channel.
    // Requests while busy are dropped. Reset clears everything.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic accept;
        logic expC;
        mEdge++;
        if (rst) begin
            mBusy = 1'b0;
            mRr   = 0;
            for (int i = 0; i < 4; i++) mRegs[i] = 12'h000;
            checkOutput("rstSSn", 64'(SS_n), 64'(1));
            checkOutput("rstSclk", 64'(SCLK), 64'(1));
            checkOutput("rstMosi", 64'(MOSI), 64'(0));
            checkOutput("rstCmplt", 64'(cnv_cmplt), 64'(0));
            checkOutput("rstRegs", 64'({lft_ld, rght_ld, steer_pot, batt}), 64'(0));
        end else begin
            accept = pNxt && !mBusy;
            expC   = 1'b0;
            if (mBusy && mEdge == mDue) begin
                mRegs[mRr] = a2dData[chanMap[mRr]][11:0];
                mRr        = (mRr + 1) % 4;
                mBusy      = 1'b0;
                expC       = 1'b1;
            end
            if (accept) begin
                mBusy = 1'b1;
                mDue  = mEdge + 1044;
            end
            checkOutput("cnvCmplt", 64'(cnv_cmplt), 64'(expC));
            checkOutput("results", 64'({lft_ld, rght_ld, steer_pot, batt}),
                        64'({mRegs[0], mRegs[1], mRegs[2], mRegs[3]}));
        end
        pNxt = nxt;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences with hand-computed expectations.
    initial begin
        int lat;
        int pulses;
        int frames0;
        for (int i = 0; i < 8; i++) a2dData[i] = 16'h0000;
        rst  = 1'b1;
        nxt  = 1'b0;
        MISO = 1'b0;

        // Reset held for 3 clk.
        repeat (3) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("resetLft", 64'(lft_ld), 64'(12'h000));
        checkOutput("resetSSn", 64'(SS_n), 64'(1));

        // Single conversion on ch0.
        $display("[TB] single conversion");
        a2dData[0] = 16'h0ABC;
        runConversion(lat);
        checkOutput("latency", 64'(lat), 64'(1044));
        checkOutput("singleCmd", 64'(lastCmdWord), 64'(16'h0000));
        checkOutput("singleLft", 64'(lft_ld), 64'(12'hABC));
        checkOutput("singleOthers", 64'({rght_ld, steer_pot, batt}), 64'(0));

        // Round-robin from a fresh reset.
        $display("[TB] round robin");
        repeat (2) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        a2dData[0] = 16'h0111;
        a2dData[4] = 16'h0222;
        a2dData[5] = 16'h0333;
        a2dData[6] = 16'h0444;
        runConversion(lat);
        checkOutput("rrCmd0", 64'(lastCmdWord), 64'(16'h0000));
        runConversion(lat);
        checkOutput("rrCmd1", 64'(lastCmdWord), 64'(16'h2000));
        checkOutput("b2bLatency", 64'(lat), 64'(1044));
        runConversion(lat);
        checkOutput("rrCmd2", 64'(lastCmdWord), 64'(16'h2800));
        runConversion(lat);
        checkOutput("rrCmd3", 64'(lastCmdWord), 64'(16'h3000));
        checkOutput("rrRegs", 64'({lft_ld, rght_ld, steer_pot, batt}), 64'(48'h111222333444));
        a2dData[0] = 16'hF123;
        runConversion(lat);
        checkOutput("rrWrapCmd", 64'(lastCmdWord), 64'(16'h0000));
        checkOutput("upperBits", 64'(lft_ld), 64'(12'h123));

        // Requests during CMD and READ are dropped.
        $display("[TB] nxt while busy");
        frames0 = frameCount;
        pulses  = 0;
        for (int k = 0; k < 1300; k++) begin
            @(posedge clk);
            #2;
            nxt = (k == 0 || k == 260 || k == 800);
            @(negedge clk);
            if (cnv_cmplt) pulses++;
        end
        checkOutput("busyPulses", 64'(pulses), 64'(1));
        checkOutput("busyFrames", 64'(frameCount - frames0), 64'(2));
        checkOutput("busyRght", 64'(rght_ld), 64'(12'h222));
        a2dData[5] = 16'h0555;
        runConversion(lat);
        checkOutput("busyNextCmd", 64'(lastCmdWord), 64'(16'h2800));
        checkOutput("busySteer", 64'(steer_pot), 64'(12'h555));

        // Reset around bit 8 of frame 2.
        $display("[TB] reset mid READ");
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            #2;
            nxt = (k == 0);
            rst = (k >= 790 && k < 793);
            @(negedge clk);
            if (k == 790) begin
                checkOutput("abortSSn", 64'(SS_n), 64'(1));
                checkOutput("abortRegs", 64'({lft_ld, steer_pot}), 64'(0));
            end
        end
        a2dData[0] = 16'h0777;
        runConversion(lat);
        checkOutput("postRstCmd", 64'(lastCmdWord), 64'(16'h0000));
        checkOutput("postRstLft", 64'(lft_ld), 64'(12'h777));
        checkOutput("postRstLat", 64'(lat), 64'(1044));

        repeat (5) applyStimulus(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/load_cell_a2d.md
# load_cell_a2d

SPI master that produces the rider load-cell readings (`lft_ld`, `rght_ld`) consumed by the steering-enable logic, plus steering-pot and battery readings, by polling an ADC128S-style 8-channel SPI A2D converter. Each `nxt` request performs one two-frame conversion on the next channel in a fixed round-robin and writes the 12-bit result into that channel's holding register. It sits between the off-chip A2D pins and the balance/steer datapath.

## Interface
- `SCLK_DIV_W`, default 5: SCLK divider width; SCLK period = 2^SCLK_DIV_W clk (32 at default).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `nxt`  in  1  one-clk request to start a conversion; ignored while busy.
- `lft_ld`  out  12  latest channel-0 result (left load cell).
- `rght_ld`  out  12  latest channel-4 result (right load cell).
- `steer_pot`  out  12  latest channel-5 result.
- `batt`  out  12  latest channel-6 result.
- `cnv_cmplt`  out  1  one-clk pulse when a holding register updates.
- `SS_n`  out  1  A2D slave select, active low.
- `SCLK`  out  1  SPI clock, idles high.
- `MOSI`  out  1  command data to A2D.
- `MISO`  in  1  result data from A2D.

## Operation
- Round-robin index `rr` (2 bits): 0→ch0/`lft_ld`, 1→ch4/`rght_ld`, 2→ch5/`steer_pot`, 3→ch6/`batt`; wraps 3→0; advances only on conversion completion.
- States: IDLE → CMD (frame 1) → GAP → READ (frame 2) → DONE → IDLE.
  - IDLE: `nxt`=1 starts CMD; `nxt` in any other state is dropped (not queued).
  - CMD: shift out 16-bit command {2'b00, ch[2:0], 11'h000}, MSB first; MISO data discarded.
  - GAP: SS_n high exactly 2 clk.
  - READ: shift out 16'h0000 (same channel repeated is not required); shift in 16 MISO bits.
  - DONE (1 clk): write shift_reg[11:0] into register selected by `rr`; bits [15:12] ignored; pulse `cnv_cmplt`; increment `rr`.
- Frame engine (shared by CMD/READ): 16-bit shift register, counter `sclk_div` (SCLK_DIV_W bits), bit counter (5 bits).
  - Frame start: SS_n←0, `sclk_div`←{1'b1, 1'b0, all-ones} (10111 at default), shift reg loaded with frame word; MOSI = shift_reg[15].
  - SCLK = `sclk_div` MSB; counter increments every clk while SS_n low.
  - MISO sampled into a holding flop on clk where `sclk_div`==01…1 (SCLK rising next).
  - Shift (left, insert sampled MISO) on clk where `sclk_div`==1…1 (SCLK falling next), except the first fall of the frame.
  - Frame ends on the clk the 16th sample has been shifted in (at the 17th fall point): SS_n←1, SCLK held high, `sclk_div` frozen.
- Holding registers only change in DONE; non-selected registers hold.

## Timing
- Reset values: `lft_ld`=`rght_ld`=`steer_pot`=`batt`=12'h000, `cnv_cmplt`=0, SS_n=1, SCLK=1, MOSI=0, `rr`=0, state IDLE.
- `nxt` at edge N → SS_n low after edge N+1.
- Per frame (default): first SCLK fall 8 clk after SS_n fall; 16 rising and 16 falling SCLK edges; SS_n low 8 + 16×32 = 520 clk.
- MOSI changes only at SCLK fall; MISO sampled only at SCLK rise.
- Total `nxt` → `cnv_cmplt`: 1 + 520 + 2 + 520 + 1 = 1044 clk; back-to-back `nxt` accepted the clk after `cnv_cmplt`.
- Reset asserted mid-frame: immediate abort, all outputs to reset values, `rr`=0; no partial write.
- All outputs registered; no combinational path from MISO or `nxt` to any output.

## Test plan
- Reset: assert `rst` 3 clk → all four results 12'h000, SS_n=1, SCLK=1, `cnv_cmplt`=0.
- Single conversion: A2D model returns 16'h0ABC on ch0; pulse `nxt` → frame-1 MOSI word 16'h0000, `cnv_cmplt` 1044 clk later, `lft_ld`=12'hABC, other registers unchanged.
- Round-robin: four `nxt`s → frame-1 MOSI words 16'h0000, 16'h2000, 16'h2800, 16'h3000; model data 12'h111/222/333/444 land in `lft_ld`/`rght_ld`/`steer_pot`/`batt`; fifth `nxt` returns to ch0.
- Frame shape: count 16 SCLK falls per frame, SCLK period 32 clk, SS_n low 520 clk, SS_n high 2 clk between frames; MISO 16'hF123 → register 12'h123.
- `nxt` during busy: pulse `nxt` mid CMD and mid READ → no extra frames, only one `cnv_cmplt`, `rr` advances by 1.
- Reset mid-READ: assert `rst` at bit 8 of frame 2 → SS_n=1 immediately, registers 12'h000, next `nxt` converts ch0.
